// File: rtl/game_controller.sv
// Connect Four turn sequencer: validates a drop request, strobes the board
// matrix for one cycle, waits for the board to settle, then sweeps every
// four-cell window looking for a line by the player who just moved.
module game_controller #(
  parameter logic FIRST_PLAYER  = 1'b0,
  parameter int   SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  sel_col,
  input  logic        drop,
  input  logic [11:0] col1,
  input  logic [11:0] col2,
  input  logic [11:0] col3,
  input  logic [11:0] col4,
  input  logic [11:0] col5,
  input  logic [11:0] col6,
  input  logic [11:0] col7,
  output logic [6:0]  O,
  output logic        player_colour,
  output logic        change,
  output logic [1:0]  win,
  output logic        busy,
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_WAIT,
    S_DROP,
    S_SETTLE,
    S_SCAN,
    S_OVER
  } state_t;

  state_t      state_q;
  logic [6:0]  o_q;
  logic        change_q;
  logic [1:0]  win_q;
  logic        busy_q;
  logic        illegal_q;
  logic        player_q;
  logic [1:0]  settle_q;
  logic [2:0]  scol_q;
  logic [2:0]  srow_q;
  logic [1:0]  sdir_q;

  // Board columns gathered into an array; entry 7 is a permanently empty
  // column so an out-of-range selection can never index past the end.
  logic [11:0] board [8];
  assign board[0] = col1;
  assign board[1] = col2;
  assign board[2] = col3;
  assign board[3] = col4;
  assign board[4] = col5;
  assign board[5] = col6;
  assign board[6] = col7;
  assign board[7] = 12'd0;

  // Two-bit cell code of row r in a column word; rows 6/7 do not exist.
  function automatic logic [1:0] cell_of(input logic [11:0] colw, input logic [2:0] r);
    logic [1:0] c;
    case (r)
      3'd0:    c = colw[1:0];
      3'd1:    c = colw[3:2];
      3'd2:    c = colw[5:4];
      3'd3:    c = colw[7:6];
      3'd4:    c = colw[9:8];
      3'd5:    c = colw[11:10];
      default: c = 2'b00;
    endcase
    return c;
  endfunction

  logic [1:0] mover_code;
  logic       sel_top_free;
  logic       window_valid;
  logic [3:0] cell_hit;
  logic       hit;
  logic [6:0] top_taken;
  logic       board_full;
  logic       last_window;

  assign mover_code   = player_q ? 2'b10 : 2'b01;
  assign sel_top_free = (board[sel_col][11:10] == 2'b00);

  // A window is checked only if all four of its cells lie on the board.
  always_comb begin
    window_valid = 1'b0;
    case (sdir_q)
      2'd0:    window_valid = (srow_q <= 3'd2);
      2'd1:    window_valid = (scol_q <= 3'd3);
      2'd2:    window_valid = (scol_q <= 3'd3) && (srow_q <= 3'd2);
      default: window_valid = (scol_q <= 3'd3) && (srow_q >= 3'd3);
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cell
      logic [2:0] c_raw;
      logic [2:0] r_raw;
      logic [2:0] c_idx;
      // Position of the gi-th cell of the current window along its direction.
      always_comb begin
        c_raw = scol_q;
        r_raw = srow_q;
        case (sdir_q)
          2'd0: r_raw = srow_q + 3'(gi);
          2'd1: c_raw = scol_q + 3'(gi);
          2'd2: begin
            c_raw = scol_q + 3'(gi);
            r_raw = srow_q + 3'(gi);
          end
          default: begin
            c_raw = scol_q + 3'(gi);
            r_raw = srow_q - 3'(gi);
          end
        endcase
        c_idx = window_valid ? c_raw : 3'd0;
      end
      assign cell_hit[gi] = (cell_of(board[c_idx], r_raw) == mover_code);
    end

    for (gi = 0; gi < 7; gi++) begin : g_top
      assign top_taken[gi] = (board[gi][11:10] != 2'b00);
    end
  endgenerate

  assign hit         = window_valid && (&cell_hit);
  assign board_full  = &top_taken;
  assign last_window = (scol_q == 3'd6) && (srow_q == 3'd5) && (sdir_q == 2'd3);

  // Turn sequencer with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_WAIT;
      o_q       <= 7'd0;
      change_q  <= 1'b0;
      win_q     <= 2'b00;
      busy_q    <= 1'b0;
      illegal_q <= 1'b0;
      player_q  <= FIRST_PLAYER;
      settle_q  <= 2'd0;
      scol_q    <= 3'd0;
      srow_q    <= 3'd0;
      sdir_q    <= 2'd0;
    end else begin
      illegal_q <= 1'b0;
      case (state_q)
        S_WAIT: begin
          if (drop) begin
            if ((sel_col > 3'd6) || !sel_top_free) begin
              illegal_q <= 1'b1;
            end else begin
              o_q      <= 7'd1 << sel_col;
              change_q <= 1'b1;
              busy_q   <= 1'b1;
              state_q  <= S_DROP;
            end
          end
        end
        S_DROP: begin
          o_q      <= 7'd0;
          change_q <= 1'b0;
          settle_q <= 2'd0;
          state_q  <= S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_q == 2'(SETTLE_CYCLES - 1)) begin
            scol_q  <= 3'd0;
            srow_q  <= 3'd0;
            sdir_q  <= 2'd0;
            state_q <= S_SCAN;
          end else begin
            settle_q <= settle_q + 2'd1;
          end
        end
        S_SCAN: begin
          if (hit) begin
            win_q   <= mover_code;
            state_q <= S_OVER;
          end else if (last_window) begin
            if (board_full) begin
              win_q   <= 2'b11;
              state_q <= S_OVER;
            end else begin
              player_q <= ~player_q;
              busy_q   <= 1'b0;
              state_q  <= S_WAIT;
            end
          end else if (sdir_q != 2'd3) begin
            sdir_q <= sdir_q + 2'd1;
          end else begin
            sdir_q <= 2'd0;
            if (srow_q != 3'd5) begin
              srow_q <= srow_q + 3'd1;
            end else begin
              srow_q <= 3'd0;
              scol_q <= scol_q + 3'd1;
            end
          end
        end
        S_OVER: begin
          o_q      <= 7'd0;
          change_q <= 1'b0;
          busy_q   <= 1'b1;
        end
        default: state_q <= S_WAIT;
      endcase
    end
  end

  assign O             = o_q;
  assign change        = change_q;
  assign win           = win_q;
  assign busy          = busy_q;
  assign illegal       = illegal_q;
  assign player_colour = player_q;

endmodule
